muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have no parameters; the data width SHALL be fixed at 32 bits.
REQ-002 The block SHALL use one clock and a synchronous, active-high reset, named `clk` and `rst`.
REQ-003 `clk` SHALL be an input, 1 bit: the single clock; all state changes on its posedge.
REQ-004 `rst` SHALL be an input, 1 bit: synchronous active-high reset.
REQ-005 `start` SHALL be an input, 1 bit: request an operation; sampled only in IDLE.
REQ-006 `op` SHALL be an input, 2 bits: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-007 `A_readdat1` SHALL be an input, 32 bits: rs operand (multiplicand / dividend), from the ID stage.
REQ-008 `B_readdat2` SHALL be an input, 32 bits: rt operand (multiplier / divisor), from the ID stage.
REQ-009 `hi_we` and `lo_we` SHALL be inputs, 1 bit each: MTHI / MTLO write strobes.
REQ-010 `writedata` SHALL be an input, 32 bits: the data for MTHI / MTLO.
REQ-011 `busy` SHALL be an output, 1 bit: operation in progress; the pipeline stalls on it.
REQ-012 `done` SHALL be an output, 1 bit: one-cycle completion pulse.
REQ-013 `div_by_zero` SHALL be an output, 1 bit: one-cycle pulse, coincident with `done`, for DIV/DIVU with B=0.
REQ-014 `hi` and `lo` SHALL be outputs, 32 bits each: the architectural HI/LO registers.

Function
REQ-015 The FSM SHALL have states IDLE, MUL, DIV, FIN.
REQ-016 Transitions:
- IDLE -> MUL on `start` with op[1]=0.
- IDLE -> DIV on `start` with op[1]=1 and B!=0.
- MUL/DIV -> FIN after exactly 32 iteration cycles (6-bit counter).
- FIN -> IDLE unconditionally.
REQ-017 At the accepting edge, operands SHALL be captured in internal registers; later changes to A/B SHALL NOT affect the result.
REQ-018 MUL SHALL be radix-2 shift-add over operand magnitudes; the signed variants record the result sign at capture.
REQ-019 DIV SHALL be restoring division over operand magnitudes, one quotient bit per cycle.
REQ-020 In FIN, sign correction SHALL be applied and HI/LO written at the FIN->IDLE edge.
REQ-021 Multiply results: HI = product[63:32], LO = product[31:0].
REQ-022 Divide results: LO = quotient truncated toward zero; HI = remainder, carrying the sign of the dividend.
REQ-023 The signed overflow case (DIV 0x80000000 / 0xFFFFFFFF) SHALL give LO=0x80000000, HI=0.
REQ-024 Latency SHALL be as follows, with start accepted at edge N:
- `busy`=1 for cycles N+1..N+33.
- `done`=1 only in cycle N+34, with the new HI/LO visible in that same cycle.
- `busy`=0 in cycle N+34.
REQ-025 DIV/DIVU with B=0 SHALL stay in IDLE and leave HI/LO unchanged; `done` and `div_by_zero` SHALL be 1 for exactly cycle N+1, with `busy` held at 0.
REQ-026 `start` while not IDLE SHALL be ignored, with no queueing.
REQ-027 `start` SHALL be accepted in the `done` cycle; back-to-back issue is legal.
REQ-028 `hi_we`/`lo_we` in IDLE SHALL write `writedata` to HI/LO at the next edge; both may be asserted together.
REQ-029 `hi_we`/`lo_we` while not IDLE SHALL be ignored.
REQ-030 `start` and `hi_we`/`lo_we` asserted together in IDLE: `start` SHALL win and the MT write SHALL be dropped.
REQ-031 `done` and `div_by_zero` SHALL be registered outputs, free of combinational paths from inputs.

Reset
REQ-032 When `rst`=1 at a posedge, the block SHALL go to IDLE with `busy`=0, `done`=0, `div_by_zero`=0, `hi`=0, `lo`=0, and counter and internal operands cleared.
REQ-033 Reset SHALL take priority over `start`, `hi_we` and `lo_we` in the same cycle.
REQ-034 Reset mid-operation SHALL abort the operation with no `done` pulse and no HI/LO update.

Verification
REQ-035 MULT A=0xFFFFFFFF (-1), B=0x00000003 -> 33 busy cycles, then `done`, HI=0xFFFFFFFF, LO=0xFFFFFFFD; MULTU with the same operands -> HI=0x00000002, LO=0xFFFFFFFD.
REQ-036 DIV A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1); DIVU A=7, B=2 -> LO=3, HI=1.
REQ-037 DIVU with B=0 after MTHI 0x11111111 / MTLO 0x22222222 -> next cycle `done`=`div_by_zero`=1, `busy` never 1, HI/LO unchanged.
REQ-038 Assert `rst` at the 10th busy cycle of a MULT -> next cycle `busy`=0, HI=LO=0, and no `done` pulse is ever seen.
REQ-039 Hold `start` plus `hi_we` with `writedata`=0xDEADBEEF during busy, then issue a new MULT 5x6 in the `done` cycle -> mid-op start and `hi_we` are ignored; the second op completes 34 cycles later with HI=0, LO=30.
REQ-040 Random signed/unsigned operands, including 0x80000000 / 0xFFFFFFFF -> HI/LO match a 64-bit reference model, with LO=0x80000000, HI=0 for the overflow case.

Source files
------------

// File: rtl/muldiv_unit_if.sv
// Handshake and data bundle between the pipeline (master) and the multiply/divide unit (slave).
interface muldiv_unit_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] A_readdat1;
  logic [31:0] B_readdat2;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] writedata;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  modport slave (
    input  start, op, A_readdat1, B_readdat2, hi_we, lo_we, writedata,
    output busy, done, div_by_zero, hi, lo
  );

  modport master (
    output start, op, A_readdat1, B_readdat2, hi_we, lo_we, writedata,
    input  busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply/divide unit owning the HI/LO registers.
// Shift-add multiply and restoring divide work on magnitudes; signs are fixed up in FIN.
module muldiv_unit (
  input  logic         clk,
  input  logic         rst,
  muldiv_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] opB_q, opB_d;
  logic [63:0] acc_q, acc_d;
  logic        negQuot_q, negQuot_d;
  logic        negRem_q, negRem_d;
  logic        isDiv_q, isDiv_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;
  logic        dbz_q, dbz_d;

  logic        opSigned;
  logic [31:0] magA, magB;
  logic [32:0] mulSum;
  logic [32:0] divShift, divDiff;
  logic [63:0] accNeg;
  logic [31:0] quotNeg, remNeg;

  assign opSigned = ~bus.op[0];
  assign magA     = (opSigned && bus.A_readdat1[31]) ? 32'd0 - bus.A_readdat1 : bus.A_readdat1;
  assign magB     = (opSigned && bus.B_readdat2[31]) ? 32'd0 - bus.B_readdat2 : bus.B_readdat2;

  // acc holds {partial product, remaining multiplier} for MUL and {remainder, quotient} for DIV.
  assign mulSum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opB_q} : 33'd0);
  assign divShift = {acc_q[63:32], acc_q[31]};
  assign divDiff  = divShift - {1'b0, opB_q};
  assign accNeg   = 64'd0 - acc_q;
  assign quotNeg  = 32'd0 - acc_q[31:0];
  assign remNeg   = 32'd0 - acc_q[63:32];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 6'd0;
      opB_q     <= 32'd0;
      acc_q     <= 64'd0;
      negQuot_q <= 1'b0;
      negRem_q  <= 1'b0;
      isDiv_q   <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      opB_q     <= opB_d;
      acc_q     <= acc_d;
      negQuot_q <= negQuot_d;
      negRem_q  <= negRem_d;
      isDiv_q   <= isDiv_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      dbz_q     <= dbz_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    opB_d     = opB_q;
    acc_d     = acc_q;
    negQuot_d = negQuot_q;
    negRem_d  = negRem_q;
    isDiv_d   = isDiv_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    dbz_d     = 1'b0;

    case (state_q)
      IDLE: begin
        // A start always wins over a simultaneous MTHI/MTLO, even a rejected divide by zero.
        if (bus.start) begin
          if (bus.op[1] && (bus.B_readdat2 == 32'd0)) begin
            done_d = 1'b1;
            dbz_d  = 1'b1;
          end else begin
            state_d   = bus.op[1] ? DIV : MUL;
            cnt_d     = 6'd0;
            opB_d     = bus.op[1] ? magB : magA;
            acc_d     = {32'd0, bus.op[1] ? magA : magB};
            negQuot_d = opSigned & (bus.A_readdat1[31] ^ bus.B_readdat2[31]);
            negRem_d  = opSigned & bus.A_readdat1[31];
            isDiv_d   = bus.op[1];
          end
        end else begin
          if (bus.hi_we) hi_d = bus.writedata;
          if (bus.lo_we) lo_d = bus.writedata;
        end
      end

      MUL: begin
        acc_d = {mulSum, acc_q[31:1]};
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) state_d = FIN;
      end

      DIV: begin
        if (!divDiff[32]) acc_d = {divDiff[31:0], acc_q[30:0], 1'b1};
        else              acc_d = {divShift[31:0], acc_q[30:0], 1'b0};
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) state_d = FIN;
      end

      FIN: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (isDiv_q) begin
          lo_d = negQuot_q ? quotNeg : acc_q[31:0];
          hi_d = negRem_q  ? remNeg  : acc_q[63:32];
        end else begin
          hi_d = negQuot_q ? accNeg[63:32] : acc_q[63:32];
          lo_d = negQuot_q ? accNeg[31:0]  : acc_q[31:0];
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Testbench for muldiv_unit: directed vectors, multi-cycle corner sequences and a
// random sweep against a 64-bit reference model, with results checked through a scoreboard queue.
module tb_muldiv_unit;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } exp_t;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  logic clk;
  logic rst;
  muldiv_unit_if bus();

  muldiv_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t        sbQueue[$];
  int          assertCount = 0;
  int          failCount   = 0;
  logic [31:0] expHi = 32'd0;
  logic [31:0] expLo = 32'd0;
  vec_t        vecs[13];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference results from plain 64-bit / int arithmetic; divide by zero leaves HI/LO alone.
  function automatic exp_t refModel(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                    input logic [31:0] curHi, input logic [31:0] curLo);
    exp_t r;
    logic signed [63:0] sa64, sb64, p;
    int sa, sb;
    r.hi = curHi; r.lo = curLo; r.dbz = 1'b0;
    case (op)
      2'b00: begin
        sa64 = {{32{a[31]}}, a};
        sb64 = {{32{b[31]}}, b};
        p = sa64 * sb64;
        r.hi = p[63:32]; r.lo = p[31:0];
      end
      2'b01: begin
        p = {32'd0, a} * {32'd0, b};
        r.hi = p[63:32]; r.lo = p[31:0];
      end
      2'b10: begin
        if (b == 32'd0) r.dbz = 1'b1;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          r.lo = 32'h8000_0000; r.hi = 32'd0;
        end else begin
          sa = a; sb = b;
          r.lo = sa / sb; r.hi = sa % sb;
        end
      end
      default: begin
        if (b == 32'd0) r.dbz = 1'b1;
        else begin
          r.lo = a / b; r.hi = a % b;
        end
      end
    endcase
    return r;
  endfunction

  // Drives one request in the current cycle; returns one cycle after the accepting edge.
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input exp_t e);
    bus.start = 1'b1; bus.op = op; bus.A_readdat1 = a; bus.B_readdat2 = b;
    sbQueue.push_back(e);
    expHi = e.hi; expLo = e.lo;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    bus.A_readdat1 = $urandom; bus.B_readdat2 = $urandom;
  endtask

  task automatic waitForDone(output int busyCycles, output bit seen);
    busyCycles = 0; seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
      if (bus.busy) busyCycles++;
      @(posedge clk); #1;
    end
  endtask

  task automatic finishOp(input string name, input int expBusy);
    int   busyCycles;
    bit   seen;
    exp_t e;
    waitForDone(busyCycles, seen);
    checkOutput({name, " done seen"}, 32'(seen), 32'd1);
    checkOutput({name, " busy cycles"}, 32'(busyCycles), 32'(expBusy));
    checkOutput({name, " busy at done"}, 32'(bus.busy), 32'd0);
    if (sbQueue.size() == 0) begin
      assertCount++; failCount++;
      $display("[TB] FAIL %s scoreboard: got done, expected no pending result", name);
    end else begin
      e = sbQueue.pop_front();
      checkOutput({name, " hi"}, bus.hi, e.hi);
      checkOutput({name, " lo"}, bus.lo, e.lo);
      checkOutput({name, " div_by_zero"}, 32'(bus.div_by_zero), 32'(e.dbz));
    end
  endtask

  initial begin
    exp_t        e;
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    int          doneCount;

    vecs[0]  = '{2'b00, 32'hFFFF_FFFF, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[1]  = '{2'b01, 32'hFFFF_FFFF, 32'h0000_0003, 32'h0000_0002, 32'hFFFF_FFFD};
    vecs[2]  = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3]  = '{2'b11, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003};
    vecs[4]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[5]  = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[6]  = '{2'b11, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF};
    vecs[7]  = '{2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[8]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[9]  = '{2'b10, 32'h0000_0003, 32'h0000_0005, 32'h0000_0003, 32'h0000_0000};
    vecs[10] = '{2'b00, 32'hFFFF_FFFE, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0002};
    vecs[11] = '{2'b10, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0003};
    vecs[12] = '{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000};

    // Reset held together with start and MT strobes must win.
    rst = 1'b1;
    bus.start = 1'b1; bus.op = 2'b00; bus.A_readdat1 = 32'd3; bus.B_readdat2 = 32'd4;
    bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.writedata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("reset busy", 32'(bus.busy), 32'd0);
    checkOutput("reset done", 32'(bus.done), 32'd0);
    checkOutput("reset div_by_zero", 32'(bus.div_by_zero), 32'd0);
    checkOutput("reset hi", bus.hi, 32'd0);
    checkOutput("reset lo", bus.lo, 32'd0);
    rst = 1'b0;
    bus.start = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    @(posedge clk); #1;

    // MTHI then MTLO, then DIVU by zero must leave them untouched.
    bus.hi_we = 1'b1; bus.writedata = 32'h1111_1111;
    @(posedge clk); #1;
    bus.hi_we = 1'b0; bus.lo_we = 1'b1; bus.writedata = 32'h2222_2222;
    @(posedge clk); #1;
    bus.lo_we = 1'b0;
    checkOutput("mthi", bus.hi, 32'h1111_1111);
    checkOutput("mtlo", bus.lo, 32'h2222_2222);
    expHi = 32'h1111_1111; expLo = 32'h2222_2222;
    e = refModel(2'b11, 32'h0000_1234, 32'd0, expHi, expLo);
    applyStimulus(2'b11, 32'h0000_1234, 32'd0, e);
    finishOp("divu by zero", 0);
    @(posedge clk); #1;
    checkOutput("dbz pulse done width", 32'(bus.done), 32'd0);
    checkOutput("dbz pulse flag width", 32'(bus.div_by_zero), 32'd0);
    checkOutput("dbz busy after", 32'(bus.busy), 32'd0);

    // Both MT strobes at once.
    bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.writedata = 32'h5A5A_5A5A;
    @(posedge clk); #1;
    bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    checkOutput("mt both hi", bus.hi, 32'h5A5A_5A5A);
    checkOutput("mt both lo", bus.lo, 32'h5A5A_5A5A);

    // Start beats a simultaneous MT write in IDLE.
    bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.writedata = 32'h9999_9999;
    e = '{32'd0, 32'd6, 1'b0};
    applyStimulus(2'b01, 32'd2, 32'd3, e);
    finishOp("start beats mt", 33);

    // Directed vectors, issued back to back in each done cycle.
    for (int i = 0; i < 13; i++) begin
      e = '{vecs[i].hi, vecs[i].lo, 1'b0};
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, e);
      finishOp($sformatf("vec%0d", i), 33);
    end

    // Random sweep against the reference model, led by the signed overflow case.
    for (int i = 0; i < 12; i++) begin
      if (i == 0) begin
        rop = 2'b10; ra = 32'h8000_0000; rb = 32'hFFFF_FFFF;
      end else begin
        rop = 2'($urandom_range(0, 3));
        ra  = $urandom;
        rb  = (i % 3 == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      end
      e = refModel(rop, ra, rb, expHi, expLo);
      applyStimulus(rop, ra, rb, e);
      finishOp($sformatf("rand%0d op%0d a=%08h b=%08h", i, rop, ra, rb), e.dbz ? 0 : 33);
    end

    // Reset on the 10th busy cycle of a MULT aborts it without a done pulse.
    bus.start = 1'b1; bus.op = 2'b00; bus.A_readdat1 = 32'd7; bus.B_readdat2 = 32'd9;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int k = 1; k < 10; k++) begin
      @(posedge clk); #1;
    end
    checkOutput("abort busy before reset", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("abort busy", 32'(bus.busy), 32'd0);
    checkOutput("abort hi", bus.hi, 32'd0);
    checkOutput("abort lo", bus.lo, 32'd0);
    expHi = 32'd0; expLo = 32'd0;
    doneCount = 0;
    for (int k = 0; k < 40; k++) begin
      if (bus.done) doneCount++;
      @(posedge clk); #1;
    end
    checkOutput("abort no done", 32'(doneCount), 32'd0);

    // Start and MTHI held through an op; the next op is taken in the done cycle.
    bus.start = 1'b1; bus.op = 2'b01; bus.A_readdat1 = 32'h0001_0000; bus.B_readdat2 = 32'h0001_0000;
    sbQueue.push_back('{32'd1, 32'd0, 1'b0});
    @(posedge clk); #1;
    bus.op = 2'b00; bus.A_readdat1 = 32'd5; bus.B_readdat2 = 32'd6;
    bus.hi_we = 1'b1; bus.writedata = 32'hDEAD_BEEF;
    sbQueue.push_back('{32'd0, 32'd30, 1'b0});
    finishOp("held start first op", 33);
    @(posedge clk); #1;
    bus.start = 1'b0;
    checkOutput("mt dropped at second start", bus.hi, 32'd1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
    end
    checkOutput("hi_we ignored while busy", bus.hi, 32'd1);
    bus.hi_we = 1'b0;
    finishOp("back to back 5x6", 28);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
